// File: rtl/dmem_responder.sv
// Data-memory responder for MEM-stage loads and stores.
// It holds a word-organised array, handles one transaction at a time,
// inserts a fixed number of wait states, merges byte-enabled stores, and
// flags misaligned or out-of-range accesses.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. The source holds valid and the payload steady until that edge.
// req_ready and resp_valid depend only on the FSM state, so neither channel
// has a combinational path into the other.
module dmem_responder #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int       DEPTH     = 1 << ADDR_WIDTH;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      state, state_next;
  logic [3:0]  cnt;
  logic        lat_write;
  logic [31:0] lat_addr, lat_wdata;
  logic [3:0]  lat_be;
  logic [31:0] rdata_q;
  logic        err_q;

  logic [31:0] mem [DEPTH];

  // Access operands: taken straight from the request when there are no wait
  // states, otherwise from the copy latched at accept time.
  logic                  acc_fire;
  logic                  acc_write;
  logic [31:0]           acc_addr, acc_wdata;
  logic [3:0]            acc_be;
  logic                  acc_err;
  logic [ADDR_WIDTH-1:0] acc_idx;

  // Next-state logic and selection of the access that happens on this edge.
  always_comb begin
    state_next = state;
    acc_fire   = 1'b0;
    acc_write  = lat_write;
    acc_addr   = lat_addr;
    acc_wdata  = lat_wdata;
    acc_be     = lat_be;
    case (state)
      S_IDLE: begin
        if (req_valid) begin
          if (WAIT_CYCLES == 0) begin
            state_next = S_RESP;
            acc_fire   = 1'b1;
            acc_write  = req_write;
            acc_addr   = req_addr;
            acc_wdata  = req_wdata;
            acc_be     = req_be;
          end else begin
            state_next = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt == 4'd1) begin
          state_next = S_RESP;
          acc_fire   = 1'b1;
        end
      end
      S_RESP: begin
        if (resp_ready) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign acc_err = (acc_addr[1:0] != 2'b00) || ((acc_addr >> (ADDR_WIDTH + 2)) != 32'd0);
  assign acc_idx = acc_addr[ADDR_WIDTH+1:2];

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Request latch, wait counter and registered response payload.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= 4'd0;
      rdata_q   <= 32'd0;
      err_q     <= 1'b0;
      lat_write <= 1'b0;
      lat_addr  <= 32'd0;
      lat_wdata <= 32'd0;
      lat_be    <= 4'd0;
    end else begin
      if (state == S_IDLE && req_valid) begin
        lat_write <= req_write;
        lat_addr  <= req_addr;
        lat_wdata <= req_wdata;
        lat_be    <= req_be;
        cnt       <= WAIT_INIT;
      end else if (state == S_WAIT) begin
        cnt <= cnt - 4'd1;
      end
      if (acc_fire) begin
        err_q   <= acc_err;
        rdata_q <= (acc_err || acc_write) ? 32'd0 : mem[acc_idx];
      end
      if (state == S_RESP && resp_ready) begin
        rdata_q <= 32'd0;
        err_q   <= 1'b0;
      end
    end
  end

  // Byte-enabled array write; reset on the same edge cancels a pending store.
  always_ff @(posedge clk) begin
    if (!rst && acc_fire && acc_write && !acc_err) begin
      for (int i = 0; i < 4; i++) begin
        if (acc_be[i]) mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
      end
    end
  end

  assign req_ready  = (state == S_IDLE);
  assign resp_valid = (state == S_RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: one instance with two wait states, one with none.
module tb_dmem_responder;

  localparam int AW = 10;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;

  // Instance with WAIT_CYCLES=2
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;

  // Instance with WAIT_CYCLES=0
  logic        req_valid0, req_ready0, req_write0;
  logic [31:0] req_addr0, req_wdata0;
  logic [3:0]  req_be0;
  logic        resp_valid0, resp_ready0, resp_err0;
  logic [31:0] resp_rdata0;

  logic [32:0] exp_q[$];
  logic [32:0] exp_q0[$];
  logic [31:0] model  [1 << AW];
  logic [31:0] model0 [1 << AW];

  int n_checks = 0;
  int n_pass   = 0;

  dmem_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(2)) u_dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  dmem_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid0), .req_ready(req_ready0), .req_write(req_write0),
    .req_addr(req_addr0), .req_wdata(req_wdata0), .req_be(req_be0),
    .resp_valid(resp_valid0), .resp_ready(resp_ready0),
    .resp_rdata(resp_rdata0), .resp_err(resp_err0)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
  endtask

  // Reference behaviour of one access; updates the chosen model array.
  task automatic model_apply(input bit sel, input bit wr, input logic [31:0] a,
                             input logic [31:0] wd, input logic [3:0] b,
                             output logic [32:0] e);
    bit          bad;
    int          idx;
    logic [31:0] w;
    bad = (a[1:0] != 2'b00) || ((a >> (AW + 2)) != 32'd0);
    idx = int'(a[AW+1:2]);
    w   = sel ? model0[idx] : model[idx];
    if (bad) begin
      e = {1'b1, 32'd0};
    end else if (wr) begin
      for (int k = 0; k < 4; k++) if (b[k]) w[8*k +: 8] = wd[8*k +: 8];
      if (sel) model0[idx] = w; else model[idx] = w;
      e = {1'b0, 32'd0};
    end else begin
      e = {1'b0, w};
    end
  endtask

  // Scoreboard monitors: compare on the cycle whose edge completes the handshake.
  always @(negedge clk) begin
    logic [32:0] e;
    if (!rst && resp_valid && resp_ready) begin
      chk("q_nonempty", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("rdata", resp_rdata, e[31:0]);
        chk("err", resp_err, e[32]);
      end
    end
  end

  always @(negedge clk) begin
    logic [32:0] e;
    if (!rst && resp_valid0 && resp_ready0) begin
      chk("w0_q_nonempty", 64'(exp_q0.size() != 0), 64'd1);
      if (exp_q0.size() != 0) begin
        e = exp_q0.pop_front();
        chk("w0_rdata", resp_rdata0, e[31:0]);
        chk("w0_err", resp_err0, e[32]);
      end
    end
  end

  // Drive a request until accepted; returns just after the accept edge.
  task automatic issue(input bit wr, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] b, input bit track);
    logic [32:0] e;
    bit ok = 1'b0;
    req_write = wr; req_addr = a; req_wdata = wd; req_be = b; req_valid = 1'b1;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (req_ready) begin
        if (track) begin
          model_apply(1'b0, wr, a, wd, b, e);
          exp_q.push_back(e);
        end
        ok = 1'b1;
      end
      @(posedge clk); #1;
    end
    chk("accept_timeout", 64'(ok), 64'd1);
    req_valid = 1'b0;
    req_addr  = $urandom;
    req_wdata = $urandom;
    req_write = 1'($urandom_range(0, 1));
    req_be    = 4'($urandom_range(0, 15));
  endtask

  // Wait until the scoreboard has consumed every expected response.
  task automatic drain();
    int i = 0;
    do begin
      @(posedge clk); #1;
      i++;
    end while (exp_q.size() != 0 && i < 40);
    chk("resp_timeout", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  task automatic xact(input bit wr, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] b);
    issue(wr, a, wd, b, 1'b1);
    drain();
  endtask

  // Zero-wait instance driver; leaves req_valid0 high for back-to-back use.
  task automatic send0(input bit wr, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] b, output int acc_cyc);
    logic [32:0] e;
    bit ok = 1'b0;
    acc_cyc = 0;
    req_write0 = wr; req_addr0 = a; req_wdata0 = wd; req_be0 = b; req_valid0 = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (req_ready0) begin
        model_apply(1'b1, wr, a, wd, b, e);
        exp_q0.push_back(e);
        acc_cyc = cyc;
        ok = 1'b1;
      end
      @(posedge clk); #1;
    end
    chk("w0_accept_timeout", 64'(ok), 64'd1);
  endtask

  initial begin
    int c_a, c_b;
    rst = 1'b1;
    req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0; req_be = 0; resp_ready = 1;
    req_valid0 = 0; req_write0 = 0; req_addr0 = 0; req_wdata0 = 0; req_be0 = 0; resp_ready0 = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_rdata", resp_rdata, 0);
    chk("rst_err", resp_err, 0);
    chk("w0_rst_req_ready", req_ready0, 1);
    chk("w0_rst_resp_valid", resp_valid0, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Full store with latency profile, then read back
    issue(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b1);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("st_wait_ready", req_ready, 0);
      chk("st_wait_valid", resp_valid, 0);
    end
    @(negedge clk);
    chk("st_resp_valid", resp_valid, 1);
    chk("st_resp_ready", req_ready, 0);
    drain();
    xact(1'b0, 32'h10, 32'h0, 4'h0);

    // Partial store and empty byte enable
    xact(1'b1, 32'h10, 32'h000000AA, 4'b0001);
    xact(1'b0, 32'h10, 32'h0, 4'h0);
    xact(1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000);
    xact(1'b0, 32'h10, 32'h0, 4'h0);

    // Misaligned and out-of-range accesses
    xact(1'b1, 32'h0, 32'hCAFEF00D, 4'hF);
    xact(1'b0, 32'h12, 32'h0, 4'h0);
    xact(1'b1, 32'h1000, 32'h55555555, 4'hF);
    xact(1'b0, 32'h0, 32'h0, 4'h0);
    xact(1'b0, 32'h8000_0000, 32'h0, 4'h0);

    // Response backpressure
    resp_ready = 1'b0;
    issue(1'b0, 32'h10, 32'h0, 4'h0, 1'b1);
    for (int k = 0; k < 10 && !resp_valid; k++) @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_valid", resp_valid, 1);
      chk("bp_req_ready", req_ready, 0);
      chk("bp_rdata", resp_rdata, 32'hDEADBEAA);
      chk("bp_err", resp_err, 0);
    end
    @(posedge clk); #1;
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_after_valid", resp_valid, 0);
    chk("bp_after_ready", req_ready, 1);
    chk("bp_after_rdata", resp_rdata, 0);
    drain();

    // Reset on the edge that would commit a store
    xact(1'b1, 32'h20, 32'h0BADF00D, 4'hF);
    issue(1'b1, 32'h20, 32'h12345678, 4'hF, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_ready", req_ready, 1);
    chk("mid_rst_valid", resp_valid, 0);
    chk("mid_rst_rdata", resp_rdata, 0);
    chk("mid_rst_err", resp_err, 0);
    xact(1'b0, 32'h20, 32'h0, 4'h0);

    // Reset and request on the same edge: reset wins
    rst = 1'b1;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h20;
    @(posedge clk); #1;
    rst = 1'b0;
    req_valid = 1'b0;
    chk("rst_req_ready_after", req_ready, 1);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("rst_req_no_resp", resp_valid, 0);
    @(posedge clk); #1;

    // Random traffic over a small initialised region
    for (int w = 0; w < 8; w++) xact(1'b1, 32'(w * 4), $urandom, 4'hF);
    for (int n = 0; n < 16; n++) begin
      logic [31:0] a;
      a = 32'($urandom_range(0, 7) * 4);
      if ($urandom_range(0, 5) == 0) a = a + 32'($urandom_range(1, 3));
      xact(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)));
    end

    // Zero-wait instance: single-cycle latency and back-to-back loads
    send0(1'b1, 32'h0, 32'h11112222, 4'hF, c_a);
    req_valid0 = 1'b0;
    @(negedge clk);
    chk("w0_lat_valid", resp_valid0, 1);
    chk("w0_lat_ready", req_ready0, 0);
    @(posedge clk); #1;
    send0(1'b1, 32'h4, 32'h33334444, 4'hF, c_a);
    req_valid0 = 1'b0;
    @(posedge clk); #1;
    send0(1'b0, 32'h0, 32'h0, 4'h0, c_a);
    send0(1'b0, 32'h4, 32'h0, 4'h0, c_b);
    req_valid0 = 1'b0;
    chk("w0_b2b_spacing", 64'(c_b - c_a), 64'd2);
    @(posedge clk); #1;
    send0(1'b0, 32'h1000, 32'h0, 4'h0, c_a);
    req_valid0 = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("w0_drain", 64'(exp_q0.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
